// File: rtl/sub_rtmd_hs.sv
// sub_rtmd_hs: retimed, valid/ready-handshaked pipelined subtractor.
//   diff = op0 - op1 (mod 2^WIDTH), borrow = (op0 < op1).
//   The subtract is split into two WIDTH/2 halves. The low-half borrow is
//   folded into the high half one stage later, so no stage has a full-width
//   borrow chain.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (op0 minuend, op1 subtrahend)
//   out_valid/out_ready result handshake (diff, borrow)
// Parameters:
//   WIDTH               operand/result width, even and >= 4
module sub_rtmd_hs #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op0,
   input  logic [WIDTH-1:0] op1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);
   localparam int H = WIDTH / 2;

   // Valid shift register: vld_q[n] qualifies stage Sn.
   logic [3:1]       vld_q, vld_d;
   logic             en;

   // S1 operand capture
   logic [WIDTH-1:0] op0_q, op1_q;
   // S2 split-half partial differences and their borrows
   logic [H-1:0]     lo_q, hi_q;
   logic             bl_q, bh_q;
   // S3 final result
   logic [H-1:0]     dlo_q, dhi_q;
   logic             brw_q;

   logic [H:0]       s2_lo_d, s2_hi_d, s3_hi_d;

   // Whole pipeline moves in lock-step. It only stalls when S3 holds a
   // result that the consumer is not taking. A bubble in S3 never blocks.
   assign en       = !vld_q[3] | out_ready;
   assign in_ready = en;

   always_comb begin
      vld_d   = {vld_q[2:1], in_valid & en};
      s2_lo_d = {1'b0, op0_q[H-1:0]}     - {1'b0, op1_q[H-1:0]};
      s2_hi_d = {1'b0, op0_q[WIDTH-1:H]} - {1'b0, op1_q[WIDTH-1:H]};
      // A low-half borrow into the high half can itself borrow out
      // (hi == 0). The final borrow is the OR of both high-half borrows.
      s3_hi_d = {1'b0, hi_q} - {{H{1'b0}}, bl_q};
   end

   // Data registers load on every advance whatever the valid bits are.
   // Only vld_q qualifies them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         op0_q <= '0;
         op1_q <= '0;
         lo_q  <= '0;
         hi_q  <= '0;
         bl_q  <= 1'b0;
         bh_q  <= 1'b0;
         dlo_q <= '0;
         dhi_q <= '0;
         brw_q <= 1'b0;
      end else if (en) begin
         vld_q        <= vld_d;
         op0_q        <= op0;
         op1_q        <= op1;
         {bl_q, lo_q} <= s2_lo_d;
         {bh_q, hi_q} <= s2_hi_d;
         dlo_q        <= lo_q;
         dhi_q        <= s3_hi_d[H-1:0];
         brw_q        <= bh_q | s3_hi_d[H];
      end
   end

   assign out_valid = vld_q[3];
   assign diff      = {dhi_q, dlo_q};
   assign borrow    = brw_q;

endmodule

// File: tb/tb_sub_rtmd_hs.sv
module tb_sub_rtmd_hs;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready, borrow;
   logic [W-1:0] op0, op1, diff;

   int tests = 0;
   int fails = 0;

   // Signals sampled just before the upcoming rising edge by step()
   logic         p_ir, p_ov, p_b, acc, xfer;
   logic [W-1:0] p_d;

   sub_rtmd_hs #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op0(op0), .op1(op1),
      .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .borrow(borrow)
   );

   always #5 clk = ~clk;

   // Reference: unsigned subtract done one bit wider. The top bit is the borrow.
   function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
      return {1'b0, a} - {1'b0, b};
   endfunction

   // Drive one cycle: set inputs at negedge, sample pre-edge handshake state,
   // then return 1 time unit after the rising edge.
   task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ordy);
      @(negedge clk);
      in_valid = iv; op0 = a; op1 = b; out_ready = ordy;
      #1;
      p_ir = in_ready; p_ov = out_valid; p_d = diff; p_b = borrow;
      acc  = iv & in_ready;
      xfer = out_valid & ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op0 = '0; op1 = '0;
      #12;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      tests++; if (diff !== '0) begin fails++; $display("FAIL reset_diff got %h exp 0", diff); end
      tests++; if (borrow !== 1'b0) begin fails++; $display("FAIL reset_borrow got %b exp 0", borrow); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_cross_half;
      step(1'b1, 32'h0001_0000, 32'h0000_0001, 1'b1);   // accept edge E
      tests++; if (!acc) begin fails++; $display("FAIL xhalf_accept got %b exp 1", acc); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL xhalf_valid_E got %b exp 0", out_valid); end
      step(1'b0, '0, '0, 1'b1);                         // E+1
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL xhalf_valid_E1 got %b exp 0", out_valid); end
      step(1'b0, '0, '0, 1'b1);                         // E+2
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL xhalf_valid_E2 got %b exp 1", out_valid); end
      tests++; if (diff !== 32'h0000_FFFF || borrow !== 1'b0) begin
         fails++; $display("FAIL xhalf_result got %h/%b exp 0000ffff/0", diff, borrow); end
      step(1'b0, '0, '0, 1'b1);
      step(1'b0, '0, '0, 1'b1);
   endtask

   task automatic test_wrap;
      logic [W-1:0] a [3] = '{32'h0000_0000, 32'h1234_5678, 32'h8000_0000};
      logic [W-1:0] b [3] = '{32'h0000_0001, 32'h1234_5678, 32'h7FFF_FFFF};
      logic [W-1:0] ed [3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      logic         eb [3] = '{1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         if (i < 3) step(1'b1, a[i], b[i], 1'b1);
         else       step(1'b0, '0, '0, 1'b1);
         if (i >= 2) begin
            tests++;
            if (out_valid !== 1'b1 || diff !== ed[i-2] || borrow !== eb[i-2]) begin
               fails++;
               $display("FAIL wrap_%0d got v=%b %h/%b exp v=1 %h/%b", i-2, out_valid, diff, borrow, ed[i-2], eb[i-2]);
            end
         end
      end
      step(1'b0, '0, '0, 1'b1);
   endtask

   task automatic test_stream;
      logic [W-1:0] a [8], b [8];
      logic [W:0]   r;
      logic         ev;
      for (int i = 0; i < 8; i++) begin a[i] = $urandom; b[i] = $urandom; end
      a[0] = b[0];   // equal operands
      b[1] = '0;     // zero subtrahend
      for (int i = 0; i < 11; i++) begin
         if (i < 8) step(1'b1, a[i], b[i], 1'b1);
         else       step(1'b0, '0, '0, 1'b1);
         ev = (i >= 2 && i < 10);
         tests++;
         if (out_valid !== ev) begin fails++; $display("FAIL stream_valid_%0d got %b exp %b", i, out_valid, ev); end
         else if (ev) begin
            r = ref_sub(a[i-2], b[i-2]);
            tests++;
            if (diff !== r[W-1:0] || borrow !== r[W]) begin
               fails++; $display("FAIL stream_data_%0d got %h/%b exp %h/%b", i-2, diff, borrow, r[W-1:0], r[W]);
            end
         end
      end
   endtask

   task automatic test_back_pressure;
      logic [W:0]   q[$];
      logic [W:0]   e;
      logic [W-1:0] sd;
      logic         sb;
      int           got;
      for (int i = 0; i < 3; i++) begin
         logic [W-1:0] x = $urandom, y = $urandom;
         step(1'b1, x, y, 1'b1);
         if (acc) q.push_back(ref_sub(x, y));
      end
      tests++; if (q.size() != 3 || out_valid !== 1'b1) begin
         fails++; $display("FAIL bp_fill got n=%0d v=%b exp n=3 v=1", q.size(), out_valid); end
      sd = diff; sb = borrow;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, $urandom, $urandom, 1'b0);   // offered operands keep changing
         tests++;
         if (p_ir !== 1'b0 || acc || out_valid !== 1'b1 || diff !== sd || borrow !== sb) begin
            fails++; $display("FAIL bp_stall_%0d got ir=%b v=%b %h/%b exp ir=0 v=1 %h/%b", i, p_ir, out_valid, diff, borrow, sd, sb);
         end
      end
      begin
         logic [W-1:0] x = 32'h0000_0000, y = 32'hFFFF_FFFF;  // diff=1, borrow=1
         step(1'b1, x, y, 1'b1);
         tests++; if (p_ir !== 1'b1 || !acc) begin fails++; $display("FAIL bp_release_ready got %b exp 1", p_ir); end
         if (acc) q.push_back(ref_sub(x, y));
      end
      got = 1;   // release edge carried a transfer
      if (xfer) begin
         e = q.pop_front();
         tests++; if (p_d !== e[W-1:0] || p_b !== e[W]) begin
            fails++; $display("FAIL bp_drain_0 got %h/%b exp %h/%b", p_d, p_b, e[W-1:0], e[W]); end
      end else got = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, '0, '0, 1'b1);
         if (xfer) begin
            got++;
            if (q.size() == 0) begin
               tests++; fails++; $display("FAIL bp_extra got %h/%b exp none", p_d, p_b);
            end else begin
               e = q.pop_front();
               tests++; if (p_d !== e[W-1:0] || p_b !== e[W]) begin
                  fails++; $display("FAIL bp_drain_%0d got %h/%b exp %h/%b", got-1, p_d, p_b, e[W-1:0], e[W]); end
            end
         end
      end
      tests++; if (got != 4 || q.size() != 0) begin
         fails++; $display("FAIL bp_count got %0d exp 4", got); end
   endtask

   task automatic test_random_stall;
      logic [W:0]   q[$];
      logic [W:0]   e;
      logic         prev_stall = 1'b0;
      logic         pv, pb;
      logic [W-1:0] pd;
      int           sent = 0, recv = 0, cyc = 0, bad = 0;
      while ((sent < 200 || recv < sent) && cyc < 5000) begin
         logic         iv = (sent < 200) ? logic'($urandom_range(0, 1)) : 1'b0;
         logic [W-1:0] x = $urandom, y = $urandom;
         step(iv, x, y, logic'($urandom_range(0, 1)));
         cyc++;
         if (prev_stall) begin
            tests++;
            if (p_ov !== pv || p_d !== pd || p_b !== pb) begin
               fails++; bad++;
               $display("FAIL rs_hold cyc %0d got %b %h/%b exp %b %h/%b", cyc, p_ov, p_d, p_b, pv, pd, pb);
            end
         end
         prev_stall = p_ov & !out_ready;
         pv = p_ov; pd = p_d; pb = p_b;
         if (acc) begin q.push_back(ref_sub(x, y)); sent++; end
         if (xfer) begin
            recv++;
            tests++;
            if (q.size() == 0) begin fails++; $display("FAIL rs_extra got %h/%b exp none", p_d, p_b); end
            else begin
               e = q.pop_front();
               if (p_d !== e[W-1:0] || p_b !== e[W]) begin
                  fails++; $display("FAIL rs_data_%0d got %h/%b exp %h/%b", recv-1, p_d, p_b, e[W-1:0], e[W]);
               end
            end
         end
      end
      tests++;
      if (sent != 200 || recv != 200) begin
         fails++; $display("FAIL rs_count got sent=%0d recv=%0d exp 200/200", sent, recv);
      end
   endtask

   task automatic test_reset_midstream;
      step(1'b1, 32'h0000_0005, 32'h0000_0009, 1'b1);
      step(1'b1, 32'h0000_0007, 32'h0000_0003, 1'b1);
      step(1'b0, '0, '0, 1'b0);
      tests++; if (out_valid !== 1'b1 || diff !== 32'hFFFF_FFFC || borrow !== 1'b1) begin
         fails++; $display("FAIL rm_pre got v=%b %h/%b exp v=1 fffffffc/1", out_valid, diff, borrow); end
      #2 rst_n = 1'b0;   // mid-cycle, away from any clock edge
      #1;
      tests++; if (out_valid !== 1'b0 || diff !== '0 || borrow !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL rm_async got v=%b %h/%b ir=%b exp v=0 0/0 ir=1", out_valid, diff, borrow, in_ready); end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, $urandom, $urandom, logic'($urandom_range(0, 1)));
         tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rm_post_%0d got %b exp 0", i, out_valid); end
      end
   endtask

   initial begin
      test_reset;
      test_cross_half;
      test_wrap;
      test_stream;
      test_back_pressure;
      test_random_stall;
      test_reset_midstream;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
